// File: rtl/uart_fifo_mmio_if.sv
// Register bus between the data_mem MMIO decode and uart_fifo_mmio.
interface uart_fifo_mmio_if;
    logic [1:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, wr_en, rd_en, wdata, input rdata);
    modport slave  (input addr, wr_en, rd_en, wdata, output rdata);
endinterface

// File: rtl/uart_fifo_mmio.sv
// Buffered UART with TX/RX FIFOs, programmable divisor, optional parity and sticky errors.
// state    | meaning
// S_IDLE   | line idle, waiting for a byte (TX) or a falling edge (RX)
// S_START  | start bit (RX: mid-bit glitch check)
// S_DATA   | DATA_BITS data bits, LSB first
// S_PARITY | parity bit, only when parity was enabled at frame start
// S_STOP   | stop bit
// S_WAIT   | RX only: after a framing error, wait for the line to return high
module uart_fifo_mmio #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int DIV_RESET = 868
) (
    input  logic             clk,
    input  logic             clr,
    uart_fifo_mmio_if.slave  bus,
    input  logic             rx,
    output logic             tx,
    output logic             irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT} state_t;

    logic w_wr_data, w_wr_stat, w_wr_div, w_wr_ctrl, w_rd_data;
    assign w_wr_data = bus.wr_en && (bus.addr == 2'd0);
    assign w_wr_stat = bus.wr_en && (bus.addr == 2'd1);
    assign w_wr_div  = bus.wr_en && (bus.addr == 2'd2);
    assign w_wr_ctrl = bus.wr_en && (bus.addr == 2'd3);
    assign w_rd_data = bus.rd_en && (bus.addr == 2'd0);

    logic w_unused_wdata;
    assign w_unused_wdata = ^bus.wdata[31:16];

    logic [15:0] r_div;
    logic [4:0]  r_ctrl;
    logic        r_rx_ovf, r_frame_err, r_parity_err, r_tx_ovf, r_irq;

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] r_txf_mem [DEPTH];
    logic [AW-1:0]        r_txf_wp, r_txf_rp;
    logic [CW-1:0]        r_txf_cnt;
    logic                 w_txf_empty, w_txf_full, w_txf_push, w_txf_pop, w_tx_ovf_set;
    logic [DATA_BITS-1:0] w_txf_head;

    assign w_txf_empty  = (r_txf_cnt == '0);
    assign w_txf_full   = (r_txf_cnt == FULL_CNT);
    assign w_txf_head   = r_txf_mem[r_txf_rp];
    assign w_txf_push   = w_wr_data && (!w_txf_full || w_txf_pop);
    assign w_tx_ovf_set = w_wr_data && w_txf_full && !w_txf_pop;

    always_ff @(posedge clk)
        if (w_txf_push) r_txf_mem[r_txf_wp] <= bus.wdata[DATA_BITS-1:0];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_txf_wp  <= '0;
            r_txf_rp  <= '0;
            r_txf_cnt <= '0;
        end else begin
            if (w_txf_push) r_txf_wp <= r_txf_wp + AW'(1);
            if (w_txf_pop)  r_txf_rp <= r_txf_rp + AW'(1);
            if (w_txf_push && !w_txf_pop)      r_txf_cnt <= r_txf_cnt + CW'(1);
            else if (!w_txf_push && w_txf_pop) r_txf_cnt <= r_txf_cnt - CW'(1);
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] r_rxf_mem [DEPTH];
    logic [AW-1:0]        r_rxf_wp, r_rxf_rp;
    logic [CW-1:0]        r_rxf_cnt;
    logic                 w_rxf_empty, w_rxf_full, w_rxf_push, w_rxf_pop, w_rx_ovf_set, w_rx_good;
    logic [DATA_BITS-1:0] r_rx_sh;

    assign w_rxf_empty  = (r_rxf_cnt == '0);
    assign w_rxf_full   = (r_rxf_cnt == FULL_CNT);
    assign w_rxf_pop    = w_rd_data && !w_rxf_empty;
    assign w_rxf_push   = w_rx_good && (!w_rxf_full || w_rxf_pop);
    assign w_rx_ovf_set = w_rx_good && w_rxf_full && !w_rxf_pop;

    always_ff @(posedge clk)
        if (w_rxf_push) r_rxf_mem[r_rxf_wp] <= r_rx_sh;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_rxf_wp  <= '0;
            r_rxf_rp  <= '0;
            r_rxf_cnt <= '0;
        end else begin
            if (w_rxf_push) r_rxf_wp <= r_rxf_wp + AW'(1);
            if (w_rxf_pop)  r_rxf_rp <= r_rxf_rp + AW'(1);
            if (w_rxf_push && !w_rxf_pop)      r_rxf_cnt <= r_rxf_cnt + CW'(1);
            else if (!w_rxf_push && w_rxf_pop) r_rxf_cnt <= r_rxf_cnt - CW'(1);
        end
    end

    // ---------------- TX FSM ----------------
    state_t               r_tx_st, w_tx_nxt;
    logic [15:0]          r_tx_tmr, r_tx_div;
    logic [DATA_BITS-1:0] r_tx_sh;
    logic [2:0]           r_tx_bit;
    logic                 r_tx_par, r_tx_pen, w_tx_tc, w_tx_busy, w_tx;

    assign w_tx_tc   = (r_tx_tmr == 16'd0);
    assign w_tx_busy = (r_tx_st != S_IDLE);

    always_ff @(posedge clk or negedge clr)
        if (!clr) r_tx_st <= S_IDLE;
        else      r_tx_st <= w_tx_nxt;

    always_comb begin
        w_tx_nxt  = r_tx_st;
        w_txf_pop = 1'b0;
        case (r_tx_st)
            S_IDLE:   if (!w_txf_empty) begin
                          w_txf_pop = 1'b1;
                          w_tx_nxt  = S_START;
                      end
            S_START:  if (w_tx_tc) w_tx_nxt = S_DATA;
            S_DATA:   if (w_tx_tc && r_tx_bit == LAST_BIT) w_tx_nxt = r_tx_pen ? S_PARITY : S_STOP;
            S_PARITY: if (w_tx_tc) w_tx_nxt = S_STOP;
            S_STOP:   if (w_tx_tc) begin
                          // back-to-back frames: next start bit follows the stop bit directly
                          w_txf_pop = !w_txf_empty;
                          w_tx_nxt  = w_txf_empty ? S_IDLE : S_START;
                      end
            default:  w_tx_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_tx = 1'b1;
        case (r_tx_st)
            S_START:  w_tx = 1'b0;
            S_DATA:   w_tx = r_tx_sh[0];
            S_PARITY: w_tx = r_tx_par;
            default:  w_tx = 1'b1;
        endcase
    end
    assign tx = w_tx;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_tx_tmr <= '0;
            r_tx_div <= '0;
            r_tx_sh  <= '0;
            r_tx_bit <= '0;
            r_tx_par <= 1'b0;
            r_tx_pen <= 1'b0;
        end else if (w_txf_pop) begin
            r_tx_sh  <= w_txf_head;
            r_tx_div <= r_div;
            r_tx_tmr <= r_div - 16'd1;
            r_tx_bit <= '0;
            r_tx_par <= (^w_txf_head) ^ r_ctrl[1];
            r_tx_pen <= r_ctrl[0];
        end else if (w_tx_busy) begin
            if (w_tx_tc) begin
                r_tx_tmr <= r_tx_div - 16'd1;
                if (r_tx_st == S_DATA) begin
                    r_tx_sh  <= r_tx_sh >> 1;
                    r_tx_bit <= r_tx_bit + 3'd1;
                end
            end else begin
                r_tx_tmr <= r_tx_tmr - 16'd1;
            end
        end
    end

    // ---------------- RX FSM ----------------
    state_t      r_rx_st, w_rx_nxt;
    logic        r_rx_s1, r_rx_s2, r_rx_prev;
    logic [15:0] r_rx_tmr, r_rx_div;
    logic [2:0]  r_rx_bit;
    logic        r_rx_pen, r_rx_odd, r_rx_perr;
    logic        w_rx_fall, w_rx_tc, w_frame_set, w_par_set;

    assign w_rx_fall = r_rx_prev && !r_rx_s2;
    assign w_rx_tc   = (r_rx_tmr == 16'd0);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
            r_rx_st   <= S_IDLE;
        end else begin
            r_rx_s1   <= rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            r_rx_st   <= w_rx_nxt;
        end
    end

    always_comb begin
        w_rx_nxt    = r_rx_st;
        w_rx_good   = 1'b0;
        w_frame_set = 1'b0;
        w_par_set   = 1'b0;
        case (r_rx_st)
            S_IDLE:   if (w_rx_fall) w_rx_nxt = S_START;
            S_START:  if (w_rx_tc) w_rx_nxt = r_rx_s2 ? S_IDLE : S_DATA;
            S_DATA:   if (w_rx_tc && r_rx_bit == LAST_BIT) w_rx_nxt = r_rx_pen ? S_PARITY : S_STOP;
            S_PARITY: if (w_rx_tc) begin
                          w_par_set = (r_rx_s2 != ((^r_rx_sh) ^ r_rx_odd));
                          w_rx_nxt  = S_STOP;
                      end
            S_STOP:   if (w_rx_tc) begin
                          w_frame_set = !r_rx_s2;
                          w_rx_good   = r_rx_s2 && !r_rx_perr;
                          w_rx_nxt    = r_rx_s2 ? S_IDLE : S_WAIT;
                      end
            S_WAIT:   if (r_rx_s2) w_rx_nxt = S_IDLE;
            default:  w_rx_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_rx_tmr  <= '0;
            r_rx_div  <= '0;
            r_rx_sh   <= '0;
            r_rx_bit  <= '0;
            r_rx_pen  <= 1'b0;
            r_rx_odd  <= 1'b0;
            r_rx_perr <= 1'b0;
        end else if (r_rx_st == S_IDLE) begin
            if (w_rx_fall) begin
                r_rx_div  <= r_div;
                r_rx_tmr  <= (r_div >> 1) - 16'd1;
                r_rx_bit  <= '0;
                r_rx_pen  <= r_ctrl[0];
                r_rx_odd  <= r_ctrl[1];
                r_rx_perr <= 1'b0;
            end
        end else if (r_rx_st != S_WAIT) begin
            if (w_rx_tc) begin
                r_rx_tmr <= r_rx_div - 16'd1;
                if (r_rx_st == S_DATA) begin
                    r_rx_sh  <= {r_rx_s2, r_rx_sh[DATA_BITS-1:1]};
                    r_rx_bit <= r_rx_bit + 3'd1;
                end
                if (r_rx_st == S_PARITY) r_rx_perr <= w_par_set;
            end else begin
                r_rx_tmr <= r_rx_tmr - 16'd1;
            end
        end
    end

    // ---------------- registers, flags, irq ----------------
    logic [3:0] w_clr;
    assign w_clr = w_wr_stat ? bus.wdata[8:5] : 4'b0;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_div        <= 16'(DIV_RESET);
            r_ctrl       <= '0;
            r_rx_ovf     <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_tx_ovf     <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            if (w_wr_div)  r_div  <= (bus.wdata[15:0] < 16'd4) ? 16'd4 : bus.wdata[15:0];
            if (w_wr_ctrl) r_ctrl <= bus.wdata[4:0];
            r_rx_ovf     <= w_rx_ovf_set | (r_rx_ovf     & ~w_clr[0]);
            r_frame_err  <= w_frame_set  | (r_frame_err  & ~w_clr[1]);
            r_parity_err <= w_par_set    | (r_parity_err & ~w_clr[2]);
            r_tx_ovf     <= w_tx_ovf_set | (r_tx_ovf     & ~w_clr[3]);
            r_irq        <= (r_ctrl[2] & ~w_rxf_empty)
                          | (r_ctrl[3] & w_txf_empty & ~w_tx_busy)
                          | (r_ctrl[4] & (r_rx_ovf | r_frame_err | r_parity_err | r_tx_ovf));
        end
    end
    assign irq = r_irq;

    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            2'd0:    if (!w_rxf_empty) bus.rdata[DATA_BITS-1:0] = r_rxf_mem[r_rxf_rp];
            2'd1:    bus.rdata[8:0] = {r_tx_ovf, r_parity_err, r_frame_err, r_rx_ovf, w_tx_busy,
                                       w_rxf_full, w_rxf_empty, w_txf_full, w_txf_empty};
            2'd2:    bus.rdata[15:0] = r_div;
            default: bus.rdata[4:0] = r_ctrl;
        endcase
    end
endmodule

// File: tb/tb_uart_fifo_mmio.sv
// Randomised self-checking bench for uart_fifo_mmio with a frame-level reference model.
module tb_uart_fifo_mmio;
    logic clk = 1'b0;
    logic clr = 1'b0;
    logic rx, tx, irq;
    logic loop_en = 1'b1;
    logic rx_drv  = 1'b1;

    uart_fifo_mmio_if bus_if();

    assign rx = loop_en ? tx : rx_drv;

    uart_fifo_mmio #(.DATA_BITS(8), .DEPTH(16), .DIV_RESET(868)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if),
        .rx  (rx),
        .tx  (tx),
        .irq (irq)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // expected line level for bit slot idx of a frame (0 start, 1..8 data, 9 parity/stop, last stop)
    function automatic logic frame_bit(input logic [7:0] b, input bit pen, input bit odd, input int idx);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == 9 && pen) return ((ones % 2) == 1) != odd;
        return 1'b1;
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.addr  = a;
        bus_if.wdata = d;
        bus_if.wr_en = 1'b1;
        @(negedge clk);
        bus_if.wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input bit pop, output logic [31:0] d);
        @(negedge clk);
        bus_if.addr  = a;
        bus_if.rd_en = pop;
        #1 d = bus_if.rdata;
        @(negedge clk);
        bus_if.rd_en = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] b, input bit pen, input bit odd, input int div,
                               input bit bad_par, input bit bad_stop);
        int n = pen ? 11 : 10;
        logic v;
        for (int k = 0; k < n; k++) begin
            v = frame_bit(b, pen, odd, k);
            if (k == 9 && pen && bad_par) v = ~v;
            if (k == n - 1 && bad_stop) v = 1'b0;
            rx_drv = v;
            repeat (div) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (div) @(negedge clk);
    endtask

    // compares tx every clock against the frames in exp_q, sent back to back
    task automatic check_tx_stream(input bit pen, input bit odd, input int div, output int lat);
        bit found = 1'b0;
        bit first = 1'b1;
        lat = -1;
        for (int t = 0; t < 4 * div + 8 && !found; t++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                found = 1'b1;
                lat   = t;
            end
        end
        chk("tx_start_seen", 32'(found), 32'd1);
        if (found) begin
            foreach (exp_q[f]) begin
                for (int k = 0; k < (pen ? 11 : 10); k++) begin
                    for (int c = 0; c < div; c++) begin
                        if (!first) @(negedge clk);
                        first = 1'b0;
                        chk($sformatf("tx_f%0d_b%0d_c%0d", f, k, c), 32'(tx), 32'(frame_bit(exp_q[f], pen, odd, k)));
                    end
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] d;
    int          lat, div, bad, found;
    bit          pen, odd;
    logic [7:0]  b, b2;

    initial begin
        bus_if.addr  = '0;
        bus_if.wr_en = 1'b0;
        bus_if.rd_en = 1'b0;
        bus_if.wdata = '0;
        repeat (3) @(negedge clk);
        bus_if.addr = 2'd1;
        #1;
        chk("rst_status", bus_if.rdata, 32'h005);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        clr = 1'b1;
        bus_read(2'd2, 1'b0, d); chk("rst_div", d, 32'd868);
        bus_read(2'd3, 1'b0, d); chk("rst_ctrl", d, 32'd0);

        bus_write(2'd2, 32'd1);
        bus_read(2'd2, 1'b0, d); chk("div_clamp", d, 32'd4);
        bus_write(2'd2, 32'd16);
        bus_read(2'd2, 1'b0, d); chk("div_16", d, 32'd16);

        // loopback 0xA5, no parity
        exp_q = '{8'hA5};
        bus_write(2'd0, 32'hA5);
        chk("tx_high_after_write", 32'(tx), 32'd1);
        check_tx_stream(1'b0, 1'b0, 16, lat);
        chk("tx_latency", 32'(lat), 32'd0);
        repeat (4) @(negedge clk);
        bus_read(2'd1, 1'b0, d); chk("lb_status", d, 32'h001);
        bus_read(2'd0, 1'b1, d); chk("lb_data", d, 32'hA5);
        bus_read(2'd1, 1'b0, d); chk("lb_popped", d, 32'h005);

        // odd parity, 0x03
        bus_write(2'd3, 32'h3);
        exp_q = '{8'h03};
        bus_write(2'd0, 32'h03);
        check_tx_stream(1'b1, 1'b1, 16, lat);
        repeat (4) @(negedge clk);
        bus_read(2'd0, 1'b1, d); chk("par_lb_data", d, 32'h03);

        loop_en = 1'b0;
        repeat (4) @(negedge clk);
        drive_frame(8'h03, 1'b1, 1'b1, 16, 1'b1, 1'b0);
        bus_read(2'd1, 1'b0, d); chk("par_err_status", d, 32'h085);
        bus_write(2'd1, 32'h80);
        bus_read(2'd1, 1'b0, d); chk("par_err_clear", d, 32'h005);

        // random frames: loopback TX+RX, then externally driven RX with optional bad parity
        for (int r = 0; r < 6; r++) begin
            div = $urandom_range(10, 24);
            pen = 1'($urandom_range(0, 1));
            odd = 1'($urandom_range(0, 1));
            b   = 8'($urandom_range(0, 255));
            loop_en = 1'b1;
            bus_write(2'd2, 32'(div));
            bus_write(2'd3, {30'b0, odd, pen});
            exp_q = '{b};
            bus_write(2'd0, 32'(b));
            check_tx_stream(pen, odd, div, lat);
            chk("rnd_latency", 32'(lat), 32'd0);
            repeat (4) @(negedge clk);
            bus_read(2'd0, 1'b1, d); chk($sformatf("rnd_lb_data%0d", r), d, 32'(b));

            loop_en = 1'b0;
            bad = pen ? $urandom_range(0, 1) : 0;
            b2  = 8'($urandom_range(0, 255));
            drive_frame(b2, pen, odd, div, bad[0], 1'b0);
            bus_read(2'd1, 1'b0, d);
            chk($sformatf("rnd_rx_status%0d", r), d, (bad != 0) ? 32'h085 : 32'h001);
            bus_read(2'd0, 1'b1, d);
            chk($sformatf("rnd_rx_data%0d", r), d, (bad != 0) ? 32'h0 : 32'(b2));
            bus_write(2'd1, 32'h1E0);
        end

        // TX FIFO boundary: 18 back-to-back writes, loopback into RX
        bus_write(2'd2, 32'd16);
        bus_write(2'd3, 32'd0);
        loop_en = 1'b1;
        exp_q.delete();
        for (int i = 0; i <= 16; i++) exp_q.push_back(8'(i));
        fork
            begin
                @(negedge clk);
                bus_if.addr  = 2'd0;
                bus_if.wr_en = 1'b1;
                for (int i = 0; i < 18; i++) begin
                    bus_if.wdata = 32'(i);
                    @(negedge clk);
                end
                bus_if.wr_en = 1'b0;
                bus_if.addr  = 2'd1;
                #1 chk("burst_status", bus_if.rdata & 32'h113, 32'h112);
            end
            check_tx_stream(1'b0, 1'b0, 16, lat);
        join
        repeat (4) @(negedge clk);
        bus_read(2'd1, 1'b0, d); chk("rx_overrun_status", d, 32'h129);
        for (int i = 0; i < 16; i++) begin
            bus_read(2'd0, 1'b1, d);
            chk($sformatf("rx_drain%0d", i), d, 32'(i));
        end
        bus_write(2'd1, 32'h1E0);
        bus_read(2'd1, 1'b0, d); chk("flags_cleared", d, 32'h005);

        // framing error, then RX must re-arm
        loop_en = 1'b0;
        drive_frame(8'h55, 1'b0, 1'b0, 16, 1'b0, 1'b1);
        bus_read(2'd1, 1'b0, d); chk("frame_err_status", d, 32'h045);
        drive_frame(8'h3C, 1'b0, 1'b0, 16, 1'b0, 1'b0);
        bus_read(2'd0, 1'b1, d); chk("after_frame_err_data", d, 32'h3C);

        bus_write(2'd3, 32'h10);
        @(negedge clk); chk("err_irq_on", 32'(irq), 32'd1);
        bus_write(2'd1, 32'h40);
        @(negedge clk); chk("err_irq_off", 32'(irq), 32'd0);

        // glitch rejection
        bus_write(2'd3, 32'h0);
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        bus_read(2'd1, 1'b0, d); chk("glitch_status", d, 32'h005);
        drive_frame(8'h96, 1'b0, 1'b0, 16, 1'b0, 1'b0);
        bus_read(2'd0, 1'b1, d); chk("after_glitch_data", d, 32'h96);

        // rx interrupt timing
        bus_write(2'd3, 32'h4);
        @(negedge clk); chk("irq_idle", 32'(irq), 32'd0);
        found = 0;
        fork
            drive_frame(8'h5A, 1'b0, 1'b0, 16, 1'b0, 1'b0);
            begin
                bus_if.addr = 2'd1;
                for (int t = 0; t < 400 && found == 0; t++) begin
                    @(negedge clk);
                    #1;
                    if (bus_if.rdata[2] == 1'b0) found = 1;
                end
                chk("irq_push_seen", 32'(found), 32'd1);
                chk("irq_at_push", 32'(irq), 32'd0);
                @(negedge clk);
                chk("irq_rise", 32'(irq), 32'd1);
            end
        join
        bus_read(2'd0, 1'b1, d); chk("irq_data", d, 32'h5A);
        chk("irq_hold", 32'(irq), 32'd1);
        @(negedge clk); chk("irq_fall", 32'(irq), 32'd0);

        bus_write(2'd3, 32'h8);
        @(negedge clk); chk("tx_irq", 32'(irq), 32'd1);

        // reset in the middle of a TX frame
        bus_write(2'd3, 32'h0);
        bus_write(2'd0, 32'h00);
        repeat (20) @(negedge clk);
        chk("tx_midframe", 32'(tx), 32'd0);
        clr = 1'b0;
        bus_if.addr = 2'd1;
        #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_status", bus_if.rdata, 32'h005);
        chk("midrst_irq", 32'(irq), 32'd0);
        bus_if.addr = 2'd2;
        #1 chk("midrst_div", bus_if.rdata, 32'd868);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_tx", 32'(tx), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/uart_fifo_mmio.md
Name: uart_fifo_mmio

Overview:
Parametrised successor to the single-byte UART behind data_mem's memory-mapped I/O window. It adds TX and RX FIFOs, a runtime-programmable baud divisor, optional parity, sticky error flags and an interrupt line. It sits between the data_mem MMIO decode and the rx/tx pins, and exposes four word-addressed registers.

Parameters:
DATA_BITS, 8, bits per character (5..8).
DEPTH, 16, entries in each FIFO (power of 2, ≥2).
DIV_RESET, 868, reset value of the divisor (clocks per bit; 100 MHz / 115200).

Ports:
clk  in  1  system clock, rising edge.
clr  in  1  asynchronous reset, active low.
addr  in  2  register select: 0 DATA, 1 STATUS, 2 DIV, 3 CTRL.
wr_en  in  1  register write strobe, one cycle.
rd_en  in  1  register read strobe; only side effect is an RX pop at addr 0.
wdata  in  32  write data.
rdata  out  32  combinational read data for the current addr; unused bits 0.
rx  in  1  serial input, asynchronous, idle high.
tx  out  1  serial output, idle high.
irq  out  1  level interrupt.

Behaviour:
- Reset (clr=0, async): tx=1, irq=0, both FIFOs empty, DIV=DIV_RESET, CTRL=0, sticky flags 0, both FSMs in IDLE. Reset mid-frame aborts the frame at once and tx returns high.
- DATA write: pushes wdata[DATA_BITS-1:0] into the TX FIFO. If the TX FIFO is full, the byte is dropped and tx_ovf is set.
- DATA read: rdata shows the RX FIFO head. A rising edge with rd_en=1 and addr=0 pops the head. If the RX FIFO is empty, rdata=0 and no pointer moves.
- STATUS read: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] tx_busy, [5] rx_ovf, [6] frame_err, [7] parity_err, [8] tx_ovf.
- STATUS write: each 1 in wdata[8:5] clears the matching sticky flag. Same-cycle set wins over clear.
- DIV register: [15:0]. Writes below 4 are clamped to 4. A new value takes effect at the next frame start; a frame in flight keeps its old divisor.
- CTRL register: [0] parity_en, [1] parity_odd (0 = even), [2] rx_irq_en, [3] tx_irq_en, [4] err_irq_en.
- irq = (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty & !tx_busy) | (err_irq_en & any sticky flag). It is a registered output, one cycle after the cause.
- FIFOs: circular, with a separate count register.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full + push + pop in the same cycle is legal.
  - Pointers wrap at DEPTH.
- TX FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - In IDLE with the FIFO non-empty, pop and latch the byte on the same edge, then enter START with tx=0.
  - Each state holds for exactly DIV clocks. DATA sends DATA_BITS bits, LSB first.
  - PARITY is present only when parity_en=1; its bit is XOR of the data (inverted for odd parity).
  - STOP drives tx=1 for DIV clocks. A queued byte then starts with no extra idle bit.
  - tx_busy = state≠IDLE.
  - TX first-edge latency: tx falls one clock after a write into an empty FIFO with the FSM idle.
- RX FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - rx passes through a 2-flop synchroniser.
  - In IDLE, a synchronised falling edge enters START. At DIV/2 clocks the line is resampled: if it is high, treat it as a glitch and return to IDLE; otherwise sample every DIV clocks thereafter.
  - Parity mismatch sets parity_err and drops the byte.
  - Stop sample = 0 sets frame_err and drops the byte. The FSM then waits for rx=1 before re-arming.
  - A good byte is pushed on the stop-sample edge. If the RX FIFO is full, the byte is dropped and rx_ovf is set.
- Divisor change while both FSMs are idle: the next frame uses the new value exactly.

Test Plan:
- Reset check: clr low mid-TX-frame with DIV=16 → tx=1 within the reset, STATUS=0x005, DIV reads 868, irq=0.
- Loopback (tx→rx), DIV=16, no parity: write 0xA5 → tx low for 16 clocks, bits 1,0,1,0,0,1,0,1 at 16 clocks each, then stop. RX FIFO then holds 0xA5, rx_empty=0, and a DATA read returns 0xA5 and pops it.
- Parity, DIV=16, parity_en=1, odd: send 0x03 → parity bit = 1, frame is 11 bits long (176 clocks). Inject a wrong parity bit → parity_err=1, byte dropped. Write 0x80 to STATUS → flag clears.
- FIFO boundaries, DEPTH=16: write 18 bytes 0x00..0x11 back-to-back → the first byte goes straight to the shifter, 16 are queued, the last is dropped and tx_ovf=1. The tx stream is 0x00..0x10 contiguous with no idle gaps.
- RX overrun and frame error: inject 17 frames with no reads → rx_full=1, rx_ovf=1, first 16 bytes intact in order. Inject a frame with stop=0 → frame_err=1, and no push occurs.
- Glitch and interrupts: a 3-clock low pulse on rx with DIV=16 → no byte, RX FSM back in IDLE. Set rx_irq_en, receive 0x5A → irq rises one clock after the push and falls one clock after the pop.
